// File: rtl/fetch_align_if.sv
// Fetch-word input, redirect and instruction output channels of the fetch aligner.
interface fetch_align_if;
    localparam int unsigned XLEN = 32;

    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_compressed;

    // Fetch/redirect source and decode sink side
    modport master (
        output flush, flush_pc, in_valid, in_rdata, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_compressed
    );

    // Aligner side
    modport slave (
        input  flush, flush_pc, in_valid, in_rdata, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_compressed
    );
endinterface

// File: rtl/fetch_align.sv
// Halfword fetch aligner: turns word-aligned fetch words into one raw RV32C/RV32I
// instruction per handshake, including word-straddling 32-bit instructions.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_align_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned HW_W  = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic [HW_W-1:0]  r_hw [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_pc;
    logic             r_skip;

    logic             w_head_c;
    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W-1:0] w_pop_n;
    logic [CNT_W-1:0] w_push_n;
    logic [CNT_W-1:0] w_keep;
    logic [CNT_W-1:0] w_count_next;
    logic [HW_W-1:0]  w_push_hw [2];
    logic [HW_W-1:0]  w_ext [DEPTH+2];
    logic [CNT_W-1:0] w_dst [DEPTH];
    logic [HW_W-1:0]  w_hw_next [DEPTH];
    logic             w_unused_ok;

    assign w_unused_ok = bus.flush_pc[0];

    // Head decode and handshake qualification
    assign w_head_c    = (r_hw[0][1:0] != 2'b11);
    assign w_out_valid = ((r_count >= CNT_W'(1)) && w_head_c) || (r_count >= CNT_W'(2));
    assign w_in_ready  = (r_count <= CNT_W'(2)) && !bus.flush;
    assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;
    assign w_push      = bus.in_valid && w_in_ready;

    assign w_pop_n  = !w_pop  ? CNT_W'(0) : (w_head_c ? CNT_W'(1) : CNT_W'(2));
    assign w_push_n = !w_push ? CNT_W'(0) : (r_skip   ? CNT_W'(1) : CNT_W'(2));

    // A halfword-aligned redirect target drops the low halfword of the first word
    assign w_push_hw[0] = r_skip ? bus.in_rdata[31:16] : bus.in_rdata[15:0];
    assign w_push_hw[1] = bus.in_rdata[31:16];

    assign w_keep       = r_count - w_pop_n;
    assign w_count_next = w_keep + w_push_n;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_ext[i] = r_hw[i];
        end
        w_ext[DEPTH]   = '0;
        w_ext[DEPTH+1] = '0;
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_dst[i] = CNT_W'(i) - w_keep;
        end
    end

    // Pop shifts survivors down; push lands right after them
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_hw_next[i] = r_hw[i];
            if (CNT_W'(i) < w_keep) begin
                w_hw_next[i] = w_ext[CNT_W'(i) + w_pop_n];
            end else if (w_dst[i] < w_push_n) begin
                w_hw_next[i] = w_push_hw[w_dst[i][0]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_hw[i] <= '0;
            end
            r_count <= '0;
            r_pc    <= {RESET_PC[31:1], 1'b0};
            r_skip  <= RESET_PC[1];
        end else if (bus.flush) begin
            r_count <= '0;
            r_pc    <= {bus.flush_pc[31:1], 1'b0};
            r_skip  <= bus.flush_pc[1];
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_hw[i] <= w_hw_next[i];
            end
            r_count <= w_count_next;
            r_pc    <= r_pc + XLEN'({w_pop_n, 1'b0});
            if (w_push) begin
                r_skip <= 1'b0;
            end
        end
    end

    // Outputs are pure functions of queue state; in_ready additionally masked by flush
    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_instr      = w_head_c ? {16'h0, r_hw[0]} : {r_hw[1], r_hw[0]};
    assign bus.out_pc         = r_pc;
    assign bus.out_compressed = (r_count != '0) && w_head_c;

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: vector table plus backpressure and async-reset sequences.
module tb_fetch_align;
    localparam logic [31:0] RST_PC = 32'h100;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_align_if bus ();

    fetch_align #(.RESET_PC(RST_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic        iv;
        logic [31:0] wd;
        logic        ord;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_c;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(logic f, logic [31:0] fp, logic iv, logic [31:0] wd, logic ord,
                                logic eir, logic eov, logic [31:0] ei, logic [31:0] ep, logic ec);
        vec_t v;
        v.flush = f;  v.fpc = fp;  v.iv = iv;  v.wd = wd;  v.ord = ord;
        v.e_ir = eir; v.e_ov = eov; v.e_instr = ei; v.e_pc = ep; v.e_c = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hwv(input int n);
        return 16'h4001 + 16'(n * 4);
    endfunction

    task automatic drive(input logic f, input logic [31:0] fp, input logic iv,
                         input logic [31:0] wd, input logic ord);
        bus.flush = f; bus.flush_pc = fp; bus.in_valid = iv; bus.in_rdata = wd; bus.out_ready = ord;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wi;
        int ri;
        logic ir;
        logic ov;
        logic [31:0] oi;
        logic [31:0] op;
        logic oc;

        vecs[0]  = mk(0, 0,     1, 32'h00A00093, 1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,     1, 32'h00B00113, 1, 1, 1, 32'h00A00093, 32'h100, 0);
        vecs[2]  = mk(0, 0,     0, 0,            1, 1, 1, 32'h00B00113, 32'h104, 0);
        vecs[3]  = mk(1, 0,     0, 0,            1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0,     1, 32'h45014485, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0,     0, 0,            1, 1, 1, 32'h00004485, 32'h0, 1);
        vecs[6]  = mk(0, 0,     0, 0,            1, 1, 1, 32'h00004501, 32'h2, 1);
        vecs[7]  = mk(1, 0,     0, 0,            1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0,     1, 32'h00934505, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0,     0, 0,            1, 1, 1, 32'h00004505, 32'h0, 1);
        vecs[10] = mk(0, 0,     0, 0,            1, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 0,     1, 32'h456100A0, 1, 1, 0, 0, 0, 0);
        vecs[12] = mk(0, 0,     0, 0,            1, 0, 1, 32'h00A00093, 32'h2, 0);
        vecs[13] = mk(0, 0,     0, 0,            1, 1, 1, 32'h00004561, 32'h6, 1);
        vecs[14] = mk(1, 32'h202, 1, 32'hAAAA4505, 1, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 0,     1, 32'h4585AAAA, 1, 1, 0, 0, 0, 0);
        vecs[16] = mk(0, 0,     0, 0,            1, 1, 1, 32'h00004585, 32'h202, 1);
        vecs[17] = mk(0, 0,     0, 0,            1, 1, 0, 0, 0, 0);
        vecs[18] = mk(0, 0,     1, 32'h45014485, 1, 1, 0, 0, 0, 0);
        vecs[19] = mk(1, 32'h10, 0, 0,           1, 0, 1, 32'h00004485, 32'h204, 1);
        vecs[20] = mk(0, 0,     1, 32'h00000013, 1, 1, 0, 0, 0, 0);
        vecs[21] = mk(0, 0,     0, 0,            1, 1, 1, 32'h00000013, 32'h10, 0);

        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset in_ready",       32'(bus.in_ready), 32'd1);
        chk("reset out_valid",      32'(bus.out_valid), 32'd0);
        chk("reset out_instr",      bus.out_instr, 32'h0);
        chk("reset out_pc",         bus.out_pc, RST_PC);
        chk("reset out_compressed", 32'(bus.out_compressed), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: inputs applied for one cycle, outputs checked before the edge
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            drive(vecs[k].flush, vecs[k].fpc, vecs[k].iv, vecs[k].wd, vecs[k].ord);
            #1;
            chk($sformatf("v%0d in_ready", k),  32'(bus.in_ready),  32'(vecs[k].e_ir));
            chk($sformatf("v%0d out_valid", k), 32'(bus.out_valid), 32'(vecs[k].e_ov));
            if (vecs[k].e_ov) begin
                chk($sformatf("v%0d out_instr", k), bus.out_instr, vecs[k].e_instr);
                chk($sformatf("v%0d out_pc", k),    bus.out_pc,    vecs[k].e_pc);
                chk($sformatf("v%0d out_comp", k),  32'(bus.out_compressed), 32'(vecs[k].e_c));
            end
        end

        // Backpressure: fill to four halfwords, then drain against a running model
        @(negedge clk);
        drive(1, 32'h300, 0, 0, 0);
        wi = 0;
        ri = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 0, wi < 8, {hwv(2*wi+1), hwv(2*wi)}, 0);
            #1 ir = bus.in_ready;
            @(posedge clk);
            if (bus.in_valid && ir) wi++;
        end
        @(negedge clk);
        drive(0, 0, wi < 8, {hwv(2*wi+1), hwv(2*wi)}, 0);
        #1;
        chk("bp saturated in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp saturated out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp head instr", bus.out_instr, {16'h0, hwv(0)});
        chk("bp words accepted", 32'(wi), 32'd2);
        for (int c = 0; c < 60 && ri < 16; c++) begin
            @(negedge clk);
            drive(0, 0, wi < 8, {hwv(2*wi+1), hwv(2*wi)}, 1);
            #1;
            ir = bus.in_ready; ov = bus.out_valid;
            oi = bus.out_instr; op = bus.out_pc; oc = bus.out_compressed;
            if (ov) begin
                chk($sformatf("bp instr %0d", ri), oi, {16'h0, hwv(ri)});
                chk($sformatf("bp pc %0d", ri),    op, 32'h300 + 32'(2*ri));
                chk($sformatf("bp comp %0d", ri),  32'(oc), 32'd1);
            end
            @(posedge clk);
            if (bus.in_valid && ir) wi++;
            if (ov) ri++;
        end
        chk("bp drained count", 32'(ri), 32'd16);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1 chk("bp empty after drain", 32'(bus.out_valid), 32'd0);

        // Async reset with three halfwords buffered
        @(negedge clk);
        drive(1, 32'h0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h45014485, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 1, 32'h45614505, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("count3 in_ready",  32'(bus.in_ready), 32'd0);
        chk("count3 out_valid", 32'(bus.out_valid), 32'd1);
        chk("count3 out_pc",    bus.out_pc, 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("async rst out_pc",    bus.out_pc, RST_PC);
        chk("async rst in_ready",  32'(bus.in_ready), 32'd1);
        chk("async rst out_instr", bus.out_instr, 32'h0);
        chk("async rst out_comp",  32'(bus.out_compressed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post reset out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
